mem_arbiter: RTL

- Shares the single SDRAM MemoryController port between four sources: CPU, PPU, ROM loader and an internal refresh timer.
- Converts each source's level req/ack handshake into the controller's one-cycle strobes (read_a, read_b, write, refresh).
- Tracks latency to the controller's data-valid point and pulses the owning requester's ack when dout_a/dout_b is valid.
- Sits between the NES core / loader and MemoryController.

---
 rtl/mem_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SDRAM MemoryController port among PPU, CPU, ROM loader and refresh.
// Build option MEM_ARB_RR_EN: CPU and loader alternate on ties instead of CPU always winning.

module mem_arbiter #(
  parameter int unsigned LAT              = 4,
  parameter int unsigned REFRESH_INTERVAL = 1500,
  parameter int unsigned REFRESH_SLACK    = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [21:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_ack,
  input  logic        ppu_req,
  input  logic [21:0] ppu_addr,
  output logic        ppu_ack,
  input  logic        ldr_req,
  input  logic [21:0] ldr_addr,
  input  logic [7:0]  ldr_din,
  output logic        ldr_ack,
  output logic        mem_read_a,
  output logic        mem_read_b,
  output logic        mem_write,
  output logic        mem_refresh,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic        mem_busy,
  output logic        refresh_miss
);

  localparam int unsigned LW = $clog2(LAT + 1);
  localparam int unsigned RW = $clog2(REFRESH_INTERVAL + 1);
  localparam int unsigned SW = $clog2(REFRESH_SLACK + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [1:0] OWN_PPU = 2'd0;
  localparam logic [1:0] OWN_CPU = 2'd1;
  localparam logic [1:0] OWN_LDR = 2'd2;
  localparam logic [1:0] OWN_REF = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [SW-1:0] slack_q, slack_d;
  logic          pend_q, pend_d;
  logic          miss_q, miss_d;
  logic          rd_a_q, rd_a_d;
  logic          rd_b_q, rd_b_d;
  logic          wr_q, wr_d;
  logic          rf_q, rf_d;
  logic [21:0]   addr_q, addr_d;
  logic [7:0]    din_q, din_d;

  logic done, ref_clear, expire, urgent, pick_cpu;

`ifdef MEM_ARB_RR_EN
  logic last_ldr_q, last_ldr_d;
  // On a CPU/loader tie, whoever was served last yields.
  assign pick_cpu = cpu_req & (~ldr_req | last_ldr_q);
`else
  assign pick_cpu = cpu_req;
`endif

  assign done      = (state_q == ST_WAIT) && (lat_q == LW'(LAT));
  assign ref_clear = done && (owner_q == OWN_REF);
  assign expire    = (rcnt_q == '0);
  assign urgent    = pend_q && (slack_q == SW'(REFRESH_SLACK));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rd_a_d  = 1'b0;
    rd_b_d  = 1'b0;
    wr_d    = 1'b0;
    rf_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_ldr_d = last_ldr_q;
`endif

    rcnt_d = expire ? RW'(REFRESH_INTERVAL - 1) : rcnt_q - RW'(1);
    // A new expiry wins over a completing refresh, so the request is never dropped.
    pend_d = expire | (pend_q & ~ref_clear);
    miss_d = miss_q | (expire & pend_q);
    slack_d = slack_q;
    if (ref_clear) begin
      slack_d = '0;
    end else if (pend_q && (slack_q != SW'(REFRESH_SLACK))) begin
      slack_d = slack_q + SW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (!mem_busy) begin
          if (urgent) begin
            owner_d = OWN_REF;
            rf_d    = 1'b1;
            state_d = ST_ISSUE;
          end else if (ppu_req) begin
            owner_d = OWN_PPU;
            rd_b_d  = 1'b1;
            addr_d  = ppu_addr;
            state_d = ST_ISSUE;
          end else if (pend_q) begin
            owner_d = OWN_REF;
            rf_d    = 1'b1;
            state_d = ST_ISSUE;
          end else if (pick_cpu) begin
            owner_d = OWN_CPU;
            rd_a_d  = ~cpu_we;
            wr_d    = cpu_we;
            addr_d  = cpu_addr;
            din_d   = cpu_din;
            state_d = ST_ISSUE;
`ifdef MEM_ARB_RR_EN
            last_ldr_d = 1'b0;
`endif
          end else if (ldr_req) begin
            owner_d = OWN_LDR;
            wr_d    = 1'b1;
            addr_d  = ldr_addr;
            din_d   = ldr_din;
            state_d = ST_ISSUE;
`ifdef MEM_ARB_RR_EN
            last_ldr_d = 1'b1;
`endif
          end
        end
      end
      ST_ISSUE: begin
        lat_d   = LW'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          state_d = ST_IDLE;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_PPU;
      lat_q   <= '0;
      rcnt_q  <= RW'(REFRESH_INTERVAL - 1);
      slack_q <= '0;
      pend_q  <= 1'b0;
      miss_q  <= 1'b0;
      rd_a_q  <= 1'b0;
      rd_b_q  <= 1'b0;
      wr_q    <= 1'b0;
      rf_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
`ifdef MEM_ARB_RR_EN
      last_ldr_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lat_q   <= lat_d;
      rcnt_q  <= rcnt_d;
      slack_q <= slack_d;
      pend_q  <= pend_d;
      miss_q  <= miss_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      wr_q    <= wr_d;
      rf_q    <= rf_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
`ifdef MEM_ARB_RR_EN
      last_ldr_q <= last_ldr_d;
`endif
    end
  end

  assign cpu_ack      = done && (owner_q == OWN_CPU);
  assign ppu_ack      = done && (owner_q == OWN_PPU);
  assign ldr_ack      = done && (owner_q == OWN_LDR);
  assign mem_read_a   = rd_a_q;
  assign mem_read_b   = rd_b_q;
  assign mem_write    = wr_q;
  assign mem_refresh  = rf_q;
  assign mem_addr     = addr_q;
  assign mem_din      = din_q;
  assign refresh_miss = miss_q;

endmodule
